// File: rtl/instruction_fetch.sv
// Instruction fetch front end: requests 32-bit words from instruction memory,
// buffers them in a small address-tagged queue and pre-decodes the head word for
// the branch facility. Vectors are descending; ISA bit k of an N-bit field is
// vector bit N-1-k, so ISA address arithmetic is plain binary arithmetic.
module instruction_fetch #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_next_instr_addr,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_instr,
    output logic [63:0] o_instr_addr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic        o_bu_en,
    output logic        o_i_form,
    output logic        o_b_form,
    output logic        o_cond_LR,
    output logic        o_cond_CTR,
    output logic        o_cond_TAR,
    output logic        o_err_unexp_rvalid
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [63:0] InstrBytes = 64'd4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     fa_q, fa_d;
    logic [63:0]     exp_q, exp_d;
    logic [63:0]     req_addr_q, req_addr_d;
    logic [63:0]     tag_q  [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    logic        empty;
    logic        head_match;
    logic        consume;
    logic        pop;
    logic        push;
    logic        redirect;
    logic        gnt_fire;
    logic [63:0] head_tag;
    logic [31:0] head_data;
    logic [5:0]  opcode;
    logic [9:0]  xo;

    assign head_tag   = tag_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign head_match = !empty && (head_tag == exp_q);
    assign consume    = head_match && i_instr_ready;
    // A head whose tag is not the expected address is prefetch past a taken branch.
    assign pop        = consume || (!empty && !head_match);
    assign push       = (state_q == StWait) && i_mem_rvalid;
    assign redirect   = consume && (i_next_instr_addr != (head_tag + InstrBytes));
    assign gnt_fire   = (state_q == StReq) && i_mem_gnt;
    assign count_d    = count_q + CntW'(push) - CntW'(pop);

    // Fetch address, expected address and request FSM next state.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        fa_d       = fa_q;
        exp_d      = consume ? i_next_instr_addr : exp_q;

        // A request made stale by an earlier redirect must not advance fa.
        if (redirect) begin
            fa_d = i_next_instr_addr;
        end else if (gnt_fire && (req_addr_q == fa_q)) begin
            fa_d = fa_q + InstrBytes;
        end

        case (state_q)
            StIdle: begin
                if (count_q < DepthCnt) begin
                    state_d    = StReq;
                    req_addr_d = fa_d;
                end
            end
            StReq: begin
                if (i_mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_mem_rvalid) begin
                    if (count_d < DepthCnt) begin
                        state_d    = StReq;
                        req_addr_d = fa_d;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request FSM and address registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            fa_q       <= '0;
            exp_q      <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            exp_q      <= exp_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Tagged instruction queue with wrap-around pointers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q]  <= req_addr_q;
                data_q[wr_ptr_q] <= i_mem_rdata;
                wr_ptr_q         <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Head presentation and branch-unit pre-decode.
    always_comb begin
        opcode     = head_data[31:26];
        xo         = head_data[10:1];
        o_i_form   = head_match && (opcode == 6'd18);
        o_b_form   = head_match && (opcode == 6'd16);
        o_cond_LR  = head_match && (opcode == 6'd19) && (xo == 10'd16);
        o_cond_CTR = head_match && (opcode == 6'd19) && (xo == 10'd528);
        o_cond_TAR = head_match && (opcode == 6'd19) && (xo == 10'd560);
        o_bu_en    = o_i_form || o_b_form || o_cond_LR || o_cond_CTR || o_cond_TAR;
    end

    assign o_instr            = head_data;
    assign o_instr_addr       = head_tag;
    assign o_instr_valid      = head_match;
    assign o_stall            = !consume;
    assign o_mem_req          = (state_q == StReq);
    assign o_mem_addr         = req_addr_q;
    assign o_err_unexp_rvalid = i_mem_rvalid && (state_q != StWait) && i_rst_n;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory responder and branch-facility model drive
// the DUT; a compare process checks every cycle against an address-level model.
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] Nop = 32'h6000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [63:0] i_next_instr_addr = '0;
    logic        o_stall;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic [31:0] o_instr;
    logic [63:0] o_instr_addr;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic        o_bu_en, o_i_form, o_b_form, o_cond_LR, o_cond_CTR, o_cond_TAR;
    logic        o_err_unexp_rvalid;

    instruction_fetch #(.DEPTH(DEPTH)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_next_instr_addr  (i_next_instr_addr),
        .o_stall            (o_stall),
        .o_mem_req          (o_mem_req),
        .o_mem_addr         (o_mem_addr),
        .i_mem_gnt          (i_mem_gnt),
        .i_mem_rvalid       (i_mem_rvalid),
        .i_mem_rdata        (i_mem_rdata),
        .o_instr            (o_instr),
        .o_instr_addr       (o_instr_addr),
        .o_instr_valid      (o_instr_valid),
        .i_instr_ready      (i_instr_ready),
        .o_bu_en            (o_bu_en),
        .o_i_form           (o_i_form),
        .o_b_form           (o_b_form),
        .o_cond_LR          (o_cond_LR),
        .o_cond_CTR         (o_cond_CTR),
        .o_cond_TAR         (o_cond_TAR),
        .o_err_unexp_rvalid (o_err_unexp_rvalid)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;

    // Stimulus controls.
    logic        rst_c = 1'b0;
    logic        ready_c = 1'b1;
    logic        gnt_c = 1'b1;
    logic        trig_en = 1'b0;
    logic [63:0] trig_addr = '0;
    int          hold_left = 0;
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;

    // Memory image; unwritten words read as nop.
    logic [31:0] mem [logic [63:0]];

    // Model state and logs.
    logic [63:0] exp_m = '0;
    logic        outstanding_m = 1'b0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [63:0] grants[$];
    logic [63:0] cons_addr[$];
    logic [5:0]  cons_strb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : Nop;
    endfunction

    // {bu_en, i_form, b_form, LR, CTR, TAR} from the ISA opcode/XO fields.
    function automatic logic [5:0] exp_strobes(input logic [31:0] w);
        int op, x;
        logic i, b, lr, ctr, tar;
        op  = int'(w >> 26);
        x   = int'((w >> 1) & 32'h3FF);
        i   = (op == 18);
        b   = (op == 16);
        lr  = (op == 19) && (x == 16);
        ctr = (op == 19) && (x == 528);
        tar = (op == 19) && (x == 560);
        return {i | b | lr | ctr | tar, i, b, lr, ctr, tar};
    endfunction

    // Branch facility: unconditional I-form branches redirect, all else is sequential.
    function automatic logic [63:0] bf_nia(input logic [63:0] a, input logic [31:0] w);
        logic [63:0] off;
        if ((w >> 26) == 32'd18) begin
            off = {{38{w[25]}}, w[25:2], 2'b00};
            return w[1] ? off : a + off;
        end
        return a + 64'd4;
    endfunction

    function automatic logic [5:0] act_strb();
        return {o_bu_en, o_i_form, o_b_form, o_cond_LR, o_cond_CTR, o_cond_TAR};
    endfunction

    // One bench cycle: drive inputs at the falling edge, return after the compare.
    task automatic tick();
        @(negedge i_clk);
        i_rst_n = rst_c;
        i_mem_rvalid = 1'b0;
        if (pend && i_rst_n) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = mem_word(pend_addr);
            pend         = 1'b0;
        end
        if (trig_en && o_instr_valid && o_mem_req && o_instr_addr == trig_addr) begin
            hold_left = 5;
            trig_en   = 1'b0;
        end
        i_mem_gnt = gnt_c && (hold_left == 0);
        if (hold_left > 0) hold_left--;
        i_instr_ready = ready_c;
        if (o_instr_valid) i_next_instr_addr = bf_nia(o_instr_addr, o_instr);
        if (o_mem_req && i_mem_gnt && i_rst_n) begin
            pend      = 1'b1;
            pend_addr = o_mem_addr;
        end
        #3;
    endtask

    task automatic do_reset();
        rst_c = 1'b0;
        tick();
        tick();
        mem.delete();
        pend = 1'b0;
        grants.delete();
        cons_addr.delete();
        cons_strb.delete();
        rst_c = 1'b1;
    endtask

    task automatic run_consumes(input int n, input string name);
        int budget;
        budget = 300;
        while (cons_addr.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_timeout"}, 64'(cons_addr.size() >= n), 64'd1);
    endtask

    // Per-cycle compare against the address-level model.
    always @(negedge i_clk) begin
        #2;
        if (!i_rst_n) begin
            check("rst_stall", o_stall, 1);
            check("rst_mem_req", o_mem_req, 0);
            check("rst_mem_addr", o_mem_addr, 0);
            check("rst_instr", o_instr, 0);
            check("rst_instr_addr", o_instr_addr, 0);
            check("rst_valid", o_instr_valid, 0);
            check("rst_strobes", act_strb(), 0);
            check("rst_err", o_err_unexp_rvalid, 0);
            exp_m         = '0;
            outstanding_m = 1'b0;
            prev_hold     = 1'b0;
        end else begin
            check("err_unexp_rvalid", o_err_unexp_rvalid, i_mem_rvalid && !outstanding_m);
            if (i_mem_rvalid) outstanding_m = 1'b0;
            if (o_instr_valid) begin
                check("head_addr", o_instr_addr, exp_m);
                check("head_instr", o_instr, mem_word(exp_m));
                check("strobes", act_strb(), exp_strobes(mem_word(exp_m)));
                check("stall_valid", o_stall, !i_instr_ready);
                if (i_instr_ready) begin
                    cons_addr.push_back(o_instr_addr);
                    cons_strb.push_back(act_strb());
                    exp_m = i_next_instr_addr;
                end
            end else begin
                check("strobes_invalid", act_strb(), 0);
                check("stall_invalid", o_stall, 1);
            end
            if (prev_hold) begin
                check("req_held", o_mem_req, 1);
                check("req_addr_held", o_mem_addr, prev_addr);
            end
            if (o_mem_req && i_mem_gnt) begin
                check("one_outstanding", outstanding_m, 0);
                outstanding_m = 1'b1;
                grants.push_back(o_mem_addr);
            end
            prev_hold = o_mem_req && !i_mem_gnt;
            prev_addr = o_mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st_instr;
        logic [63:0] st_addr;
        int          budget;

        // Reset state.
        repeat (3) tick();
        check("reset_stall", o_stall, 1);
        check("reset_mem_req", o_mem_req, 0);

        // Sequential nops.
        rst_c = 1'b1;
        run_consumes(3, "seq");
        check("seq_grant0", grants[0], 64'h0);
        check("seq_grant1", grants[1], 64'h4);
        check("seq_grant2", grants[2], 64'h8);
        check("seq_cons0", cons_addr[0], 64'h0);
        check("seq_cons1", cons_addr[1], 64'h4);
        check("seq_cons2", cons_addr[2], 64'h8);
        check("seq_bu_en", 64'(cons_strb[0] | cons_strb[1] | cons_strb[2]), 64'h0);

        // Taken branch at 0 to 0x100; prefetched word at 4 is discarded.
        do_reset();
        mem[64'h0] = 32'h4800_0100;
        run_consumes(2, "br");
        check("br_strobes", cons_strb[0], 6'b110000);
        check("br_cons1", cons_addr[1], 64'h100);
        check("br_grant1", grants[1], 64'h4);
        check("br_grant2", grants[2], 64'h100);

        // Downstream stall fills the queue; then it drains back-to-back.
        do_reset();
        ready_c = 1'b0;
        budget = 50;
        while (!o_instr_valid && budget > 0) begin
            tick();
            budget--;
        end
        check("stall_head_timeout", o_instr_valid, 1);
        st_instr = o_instr;
        st_addr  = o_instr_addr;
        check("stall_head_addr", st_addr, 64'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_instr_stable", o_instr, st_instr);
            check("stall_addr_stable", o_instr_addr, st_addr);
            if (k >= 4) check("stall_no_req", o_mem_req, 0);
        end
        ready_c = 1'b1;
        repeat (DEPTH) tick();
        check("drain_count", 64'(cons_addr.size()), 64'(DEPTH));
        check("drain_cons0", cons_addr[0], 64'h0);
        check("drain_cons1", cons_addr[1], 64'h4);

        // Redirect to 0x200 while the grant for 8 is withheld.
        do_reset();
        mem[64'h4] = 32'h4800_01FC;
        trig_addr = 64'h4;
        trig_en   = 1'b1;
        run_consumes(3, "redir");
        check("redir_trigger", trig_en, 0);
        check("redir_grant2", grants[2], 64'h8);
        check("redir_grant3", grants[3], 64'h200);
        check("redir_cons1", cons_addr[1], 64'h4);
        check("redir_cons2", cons_addr[2], 64'h200);

        // XL-form conditional branches and a B-form branch.
        do_reset();
        mem[64'h0]  = 32'h4C00_0020;
        mem[64'h4]  = 32'h4C00_0420;
        mem[64'h8]  = 32'h4C00_0460;
        mem[64'hC]  = 32'h4C00_0000;
        mem[64'h10] = 32'h4000_0000;
        run_consumes(5, "cond");
        check("cond_lr", cons_strb[0], 6'b100100);
        check("cond_ctr", cons_strb[1], 6'b100010);
        check("cond_tar", cons_strb[2], 6'b100001);
        check("cond_none", cons_strb[3], 6'b000000);
        check("cond_bform", cons_strb[4], 6'b101000);

        // Reset while a request is outstanding; its late response is stray.
        budget = 50;
        while (!pend && budget > 0) begin
            tick();
            budget--;
        end
        check("wait_timeout", pend, 1);
        @(posedge i_clk);
        #1;
        rst_c   = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_stall", o_stall, 1);
        check("mid_rst_req", o_mem_req, 0);
        check("mid_rst_valid", o_instr_valid, 0);
        check("mid_rst_instr", o_instr, 0);
        repeat (3) tick();
        grants.delete();
        rst_c = 1'b1;
        tick();
        check("stray_rvalid", i_mem_rvalid, 1);
        check("stray_err", o_err_unexp_rvalid, 1);
        tick();
        check("stray_err_clear", o_err_unexp_rvalid, 0);
        budget = 50;
        while (grants.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("restart_timeout", 64'(grants.size() > 0), 64'd1);
        check("restart_addr", grants[0], 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
